ka_mult_iter: RTL and testbench
===============================

Name: ka_mult_iter

Overview:
- Parametrised, multi-cycle Karatsuba multiplier for the NTT butterfly datapath; next generation of the fixed 32x32 combinational Karatsuba multiplier.
- Computes a W x W unsigned product by reusing one (W/2+1)-bit half-width multiplier over three cycles, then combines the partial products.
- Valid/ready handshakes on input and output let it sit between the operand fetch stage and the modular reduction stage.

Parameters:
W, 32, operand width; even, >= 4.
HW, W/2, half width; derived localparam, not overridable.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
in_a  in  W  multiplicand, unsigned
in_b  in  W  multiplier, unsigned
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_p  out  2W  product in_a*in_b
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: out_valid=0, out_p=0, busy=0, in_ready=1, FSM state=IDLE, internal registers=0. Reset takes effect immediately and works in any state.
- Accept: operands are accepted on a rising edge where in_valid && in_ready. in_a and in_b are latched at that edge. Split: aH = a[W-1:HW], aL = a[HW-1:0]; same split for b.
- FSM states and transitions, one cycle per state unless noted:
  - IDLE -> MUL_HH on accept.
  - MUL_HH: HH = aH*bH is registered. Next state MUL_LL.
  - MUL_LL: LL = aL*bL is registered. Next state MUL_MID.
  - MUL_MID: MID = (aH+aL)*(bH+bL) is registered. Operands are HW+1 bits; MID is 2HW+2 bits. Next state COMBINE.
  - COMBINE: out_p = (HH<<W) + ((MID-HH-LL)<<HW) + LL is registered.
    - The MID-HH-LL term is never negative and fits in W+2 bits.
    - The sum is computed at 2W+2 bits and truncated to 2W bits; the true result never exceeds 2W bits.
    - Next state DONE.
  - DONE: out_valid=1.
    - If out_ready=1 and in_valid=1, the new operands are accepted in the same cycle and the next state is MUL_HH (back-to-back operation).
    - If out_ready=1 and in_valid=0, the next state is IDLE.
    - If out_ready=0, the block holds DONE.
- Latency: accept at edge t gives out_valid high during the cycle after edge t+4. That is 5 cycles. Throughput is 1 product per 5 cycles.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from out_ready.
- Under back-pressure (DONE with out_ready=0), out_p and out_valid hold stable. in_a and in_b are ignored while in_ready=0.
- out_p holds its last value outside DONE. Consumers must qualify it with out_valid.
- Only one half-width multiplier instance exists. Its operands are muxed by state: HH, LL or MID.

Optional Feature:
- Macro: KA_ZERO_SKIP_EN.
- Defined: if in_a==0 or in_b==0 at accept, the FSM goes directly to DONE with out_p=0. out_valid rises one cycle after the accept edge. All other operand pairs take the normal 5-cycle path.
- Undefined: every operand pair takes 5 cycles, including zeros. No zero-detect logic is synthesised.

Decomposition:
- Shared package (ntt_pkg) holds:
  - the FSM state enum (IDLE, MUL_HH, MUL_LL, MUL_MID, COMBINE, DONE);
  - the default width constant NTT_W = 32.
- Sub-module ka_half_mult: combinational (HW+1) x (HW+1) unsigned multiplier with a 2HW+2-bit output. It is parametrised by width so it can later be replaced by a recursive Karatsuba tree.

Test Plan:
- W=8: in_a=0xFF, in_b=0xFF, out_ready=1 -> out_valid 5 cycles after accept, out_p=0xFE01, then FSM returns to IDLE.
- W=8: 0xA5 x 0x5A -> out_p=0x3A02. W=32: 0xFFFFFFFF x 0xFFFFFFFF -> out_p=0xFFFFFFFE00000001. W=32: 0x80000000 x 0x00000003 -> out_p=0x0000000180000000.
- Back-pressure: hold out_ready=0 for 3 cycles in DONE -> out_valid=1, out_p stable, in_ready=0; release -> one transfer, no duplicate.
- Back-to-back: in_valid held high with a stream of 4 operand pairs, out_ready=1 -> products arrive every 5 cycles and in_ready pulses in DONE.
- Reset mid-operation: assert rst during MUL_MID -> out_valid=0, out_p=0, busy=0, in_ready=1 immediately; the next operation gives the correct product.
- With KA_ZERO_SKIP_EN: 0x00000000 x 0x12345678 -> out_p=0, out_valid 1 cycle after accept. Without the macro: same result after 5 cycles.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT datapath types: Karatsuba FSM states and default operand width.
// No logic; latency and backpressure are defined by the modules importing it.
// Consumed by ka_mult_iter and its sub-modules.
package ntt_pkg;

  localparam int NTT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    MUL_HH,
    MUL_LL,
    MUL_MID,
    COMBINE,
    DONE
  } ka_state_t;

endpackage

// File: rtl/ka_half_mult.sv
// Combinational N x N unsigned multiplier; the shared half-width engine.
// Zero latency, no handshake; the caller owns sequencing and backpressure.
// Kept standalone so a recursive Karatsuba tree can replace it later.
module ka_half_mult #(
  parameter int N = 17
) (
  input  logic [N-1:0]   op_a,
  input  logic [N-1:0]   op_b,
  output logic [2*N-1:0] prod
);

  assign prod = {{N{1'b0}}, op_a} * {{N{1'b0}}, op_b};

endmodule

// File: rtl/ka_mult_iter.sv
// Iterative W x W Karatsuba multiplier; one (W/2+1)-bit multiplier reused over three cycles.
// Latency 5 cycles accept-to-out_valid (1 cycle for zero operands when KA_ZERO_SKIP_EN is defined).
// Back-pressure holds DONE with out_p stable; in_ready is combinational from out_ready in DONE.
module ka_mult_iter
  import ntt_pkg::*;
#(
  parameter int W = NTT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  localparam int HW = W / 2;

  ka_state_t      state;
  ka_state_t      state_nxt;
  ka_state_t      start_state;
  logic           accept;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   hh_q;
  logic [W-1:0]   ll_q;
  logic [W+1:0]   mid_q;
  logic [HW:0]    mul_a;
  logic [HW:0]    mul_b;
  logic [W+1:0]   mul_p;
  logic [W+1:0]   mid_term;
  logic [2*W+1:0] comb_sum;
  logic [1:0]     sum_unused;

  assign accept = in_valid && in_ready;

`ifdef KA_ZERO_SKIP_EN
  assign start_state = (in_a == '0 || in_b == '0) ? DONE : MUL_HH;
`else
  assign start_state = MUL_HH;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_state;
      MUL_HH:  state_nxt = MUL_LL;
      MUL_LL:  state_nxt = MUL_MID;
      MUL_MID: state_nxt = COMBINE;
      COMBINE: state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? start_state : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || (state == DONE && out_ready);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Single multiplier; the state selects which partial product it serves.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_HH: begin
        mul_a = {1'b0, a_q[W-1:HW]};
        mul_b = {1'b0, b_q[W-1:HW]};
      end
      MUL_LL: begin
        mul_a = {1'b0, a_q[HW-1:0]};
        mul_b = {1'b0, b_q[HW-1:0]};
      end
      MUL_MID: begin
        mul_a = {1'b0, a_q[W-1:HW]} + {1'b0, a_q[HW-1:0]};
        mul_b = {1'b0, b_q[W-1:HW]} + {1'b0, b_q[HW-1:0]};
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  ka_half_mult #(
    .N(HW + 1)
  ) u_half_mult (
    .op_a(mul_a),
    .op_b(mul_b),
    .prod(mul_p)
  );

  // MID-HH-LL equals aH*bL+aL*bH, so it is never negative and fits W+2 bits.
  always_comb begin
    mid_term = mid_q - {2'b00, hh_q} - {2'b00, ll_q};
    comb_sum = {2'b00, hh_q, {W{1'b0}}}
             + {{(W-HW){1'b0}}, mid_term, {HW{1'b0}}}
             + {{(W+2){1'b0}}, ll_q};
  end

  // The true product never reaches the top two bits of the wide sum.
  assign sum_unused = comb_sum[2*W+1:2*W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      hh_q  <= '0;
      ll_q  <= '0;
      mid_q <= '0;
      out_p <= '0;
    end else begin
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      case (state)
        MUL_HH:  hh_q  <= mul_p[W-1:0];
        MUL_LL:  ll_q  <= mul_p[W-1:0];
        MUL_MID: mid_q <= mul_p;
        COMBINE: out_p <= comb_sum[2*W-1:0];
        default: ;
      endcase
`ifdef KA_ZERO_SKIP_EN
      if (accept && start_state == DONE) out_p <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_ka_mult_iter.sv
// Self-checking bench for ka_mult_iter: cycle-level transaction model plus directed literals.
// Covers W=32 (model-checked every cycle) and a small W=8 instance with directed cases.
module tb_ka_mult_iter;

  localparam int W = 32;
`ifdef KA_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   in_a, in_b;
  logic [2*W-1:0] out_p;

  logic        v8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  ka_mult_iter #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy)
  );

  ka_mult_iter #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(or8),
    .out_p(p8), .busy(busy8)
  );

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight; out_valid from (accept edge + 4) until taken.
  bit              m_pend = 1'b0;
  longint unsigned m_edge = 0;
  longint unsigned m_done = 0;
  logic [63:0]     m_p    = '0;

  always @(posedge clk) begin
    bit ov, rdy;
    cyc++;
    ov  = m_pend && (m_edge >= m_done);
    rdy = !m_pend || (ov && out_ready);
    m_edge++;
    if (rst) begin
      m_pend = 1'b0;
    end else begin
      if (ov && out_ready) m_pend = 1'b0;
      if (in_valid && rdy) begin
        m_pend = 1'b1;
        m_p    = 64'(in_a) * 64'(in_b);
        m_done = m_edge + ((SKIP && (in_a == 0 || in_b == 0)) ? 0 : 4);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_ov;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_out_p", out_p, 0);
    end else begin
      exp_ov = m_pend && (m_edge >= m_done);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, !m_pend || (exp_ov && out_ready));
      chk("busy", busy, m_pend);
      if (exp_ov) chk("out_p", out_p, m_p);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int lat;
    a8 = a; b8 = b; v8 = 1'b1; or8 = 1'b1;
    @(negedge clk);
    chk("w8_in_ready", ir8, 1);
    @(posedge clk); #2;
    v8 = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (ov8) break;
    end
    chk("w8_latency", lat, 5);
    chk("w8_out_p", p8, exp);
    @(posedge clk); #2;
    chk("w8_back_idle", busy8, 0);
    chk("w8_valid_drop", ov8, 0);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int exp_lat);
    int lat;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("w32_in_ready", in_ready, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("w32_latency", lat, exp_lat);
    chk("w32_out_p", out_p, exp);
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("idle_timeout", ok, 1);
    @(posedge clk); #2;
  endtask

  logic [31:0] ba [4] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001, 32'hDEAD_BEEF};
  logic [31:0] bb [4] = '{32'h9ABC_DEF0, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0BAD_F00D};

  initial begin
    int acc_cyc [4];
    bit r;
    in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    v8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;

    @(negedge clk);
    chk("reset_ov8", ov8, 0);
    chk("reset_ir8", ir8, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    run8(8'hFF, 8'hFF, 16'hFE01);
    run8(8'hA5, 8'h5A, 16'h3A02);

    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);
    run32(32'h8000_0000, 32'h0000_0003, 64'h0000_0001_8000_0000, 5);
    run32(32'h0000_00A5, 32'h0000_005A, 64'h0000_0000_0000_3A02, 5);
    run32(32'h0000_0000, 32'h1234_5678, 64'h0, SKIP ? 1 : 5);
    run32(32'h0000_0007, 32'h0000_0006, 64'd42, 5);

    // Back-pressure: hold DONE, offer unrelated operands that must be ignored.
    in_a = 32'h0001_0001; in_b = 32'h0001_0001; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_valid", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      in_valid = 1'b1; in_a = 32'h5555_5555; in_b = 32'h3;
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_p", out_p, 64'h0000_0001_0002_0001);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #2;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    chk("bp_no_dup", out_valid, 0);
    chk("bp_idle", busy, 0);
    @(posedge clk); #2;

    // Back-to-back stream with in_valid held high.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = ba[i]; in_b = bb[i]; in_valid = 1'b1;
      r = 1'b0;
      for (int t = 0; t < 20 && !r; t++) begin
        @(negedge clk);
        r = in_ready;
        @(posedge clk);
      end
      #2;
      chk("b2b_accepted", r, 1);
      acc_cyc[i] = cyc;
      if (i > 0) chk("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 5);
    end
    wait_idle();

    // Asynchronous reset while in MUL_MID.
    in_a = 32'hCAFE_BABE; in_b = 32'h1357_9BDF; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_p", out_p, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    run32(32'h0000_FFFF, 32'h0001_0000, 64'h0000_0000_FFFF_0000, 5);

    // Randomized traffic checked cycle-by-cycle against the model.
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_a      = pick();
      in_b      = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #2;
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
